// File: rtl/padbi_pkg.sv
// padbi_pkg: shared state codes and pad direction constants for the padbi sequencer
package padbi_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] TURN = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic DIR_IN = 1'b0;
  localparam logic DIR_OUT = 1'b1;
endpackage

// File: rtl/padbi_seq_if.sv
// padbi_seq_if: core request handshake plus pad EN/DIR/data bundle
interface padbi_seq_if #(parameter int WIDTH = 8);
  logic req;
  logic wr;
  logic [WIDTH-1:0] wdata;
  logic ack;
  logic [WIDTH-1:0] rdata;
  logic en;
  logic dir;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] din;
  modport master(output req, wr, wdata, din, input ack, rdata, en, dir, dout);
  modport slave(input req, wr, wdata, din, output ack, rdata, en, dir, dout);
endinterface

// File: rtl/padbi_dcnt.sv
// padbi_dcnt: loadable down-counter, terminal count asserted at value 1
module padbi_dcnt #(parameter int W = 2) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         tc
);
  always_ff @(posedge clk)
    if (!nreset) q <= '0;
    else if (load) q <= d;
    else if (q != '0) q <= q - W'(1);
  assign tc = q == W'(1);
endmodule

// File: rtl/padbi_seq.sv
// padbi_seq: single-word pad bus sequencer with tri-state turnaround on direction change
module padbi_seq
  import padbi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TURN_CYCLES = 2,
  parameter int XFER_CYCLES = 3
) (
  input logic clk,
  input logic nreset,
  padbi_seq_if.slave bus
);
  localparam int MAXC = TURN_CYCLES > XFER_CYCLES ? TURN_CYCLES : XFER_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  logic [1:0] state;
  logic wr_q;
  logic [WIDTH-1:0] wdata_q;
  logic ld;
  logic tc;
  logic turn;
  logic [CW-1:0] ld_val;
  logic [CW-1:0] cnt;
  always_comb begin
    turn = bus.wr != bus.dir;
    ld = (state == IDLE && bus.req) || (state == TURN && tc);
    ld_val = (state == IDLE && turn) ? CW'(TURN_CYCLES) : CW'(XFER_CYCLES);
  end
  padbi_dcnt #(.W(CW)) u_dcnt (
    .clk(clk),
    .nreset(nreset),
    .load(ld),
    .d(ld_val),
    .q(cnt),
    .tc(tc)
  );
  // DIR only moves in IDLE, while EN is low; EN rises a cycle later at the earliest
  always_ff @(posedge clk)
    if (!nreset) begin
      state <= IDLE;
      wr_q <= 1'b0;
      wdata_q <= '0;
      bus.en <= 1'b0;
      bus.dir <= DIR_IN;
      bus.dout <= '0;
      bus.rdata <= '0;
      bus.ack <= 1'b0;
    end else begin
      bus.ack <= 1'b0;
      case (state)
        IDLE:
          if (bus.req) begin
            wr_q <= bus.wr;
            wdata_q <= bus.wdata;
            bus.dir <= bus.wr;
            state <= turn ? TURN : XFER;
            bus.en <= !turn;
            if (!turn && bus.wr) bus.dout <= bus.wdata;
          end
        TURN:
          if (tc) begin
            state <= XFER;
            bus.en <= 1'b1;
            if (wr_q) bus.dout <= wdata_q;
          end
        XFER:
          if (tc) begin
            state <= DONE;
            bus.en <= 1'b0;
            bus.ack <= 1'b1;
            if (!wr_q) bus.rdata <= bus.din;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_padbi_seq.sv
// tb_padbi_seq: directed checks of padbi_seq timing, turnaround, busy-ignore and reset abort
module tb_padbi_seq;
  logic clk = 1'b0;
  logic nreset;
  int n_chk = 0;
  int n_fail = 0;
  padbi_seq_if #(.WIDTH(8)) bus ();
  padbi_seq #(.WIDTH(8), .TURN_CYCLES(2), .XFER_CYCLES(3)) dut (
    .clk(clk),
    .nreset(nreset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic xfer(input logic w, input logic [7:0] d, input int turn, input logic [7:0] rexp);
    bus.req = 1'b1;
    bus.wr = w;
    bus.wdata = d;
    for (int c = 1; c <= turn + 4; c++) begin
      tick;
      bus.req = 1'b0;
      check("en", bus.en, c > turn && c <= turn + 3);
      check("dir", bus.dir, w);
      check("ack", bus.ack, c == turn + 4);
      if (w && c > turn && c <= turn + 3) check("dout", bus.dout, d);
    end
    if (!w) check("rdata", bus.rdata, rexp);
    tick;
  endtask
  initial begin
    int a1;
    int a2;
    int acks;
    nreset = 1'b0;
    bus.req = 1'($urandom);
    bus.wr = 1'($urandom);
    bus.wdata = 8'($urandom);
    bus.din = 8'($urandom);
    @(negedge clk);
    tick;
    tick;
    check("rst_en", bus.en, 0);
    check("rst_dir", bus.dir, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_ack", bus.ack, 0);
    bus.req = 1'b0;
    nreset = 1'b1;
    tick;
    xfer(1'b1, 8'hA5, 2, 8'h00);
    bus.din = 8'h3C;
    xfer(1'b0, 8'h00, 2, 8'h3C);
    bus.din = 8'h99;
    for (int i = 0; i < 10; i++) tick;
    check("rdata_hold", bus.rdata, 8'h3C);
    // back-to-back writes with req held high
    a1 = -1;
    a2 = -1;
    bus.req = 1'b1;
    bus.wr = 1'b1;
    bus.wdata = 8'h11;
    for (int c = 1; c <= 20 && a2 < 0; c++) begin
      tick;
      if (a1 >= 0) check("b2b_dir", bus.dir, 1);
      if (bus.ack) begin
        if (a1 < 0) begin
          a1 = c;
          bus.wdata = 8'h22;
        end else begin
          a2 = c;
          bus.req = 1'b0;
        end
      end
    end
    check("b2b_ack1", a1, 6);
    check("b2b_gap", a2 - a1, 5);
    check("b2b_dout", bus.dout, 8'h22);
    tick;
    // busy-ignore: inputs change mid transfer
    acks = 0;
    bus.req = 1'b1;
    bus.wr = 1'b1;
    bus.wdata = 8'h5A;
    for (int c = 1; c <= 8; c++) begin
      tick;
      bus.req = 1'b0;
      if (c == 1) begin
        bus.wdata = 8'hFF;
        bus.wr = 1'b0;
      end
      if (c == 2) bus.wr = 1'b1;
      if (c == 3) bus.wr = 1'b0;
      if (bus.ack) acks++;
      if (c <= 3) begin
        check("busy_en", bus.en, 1);
        check("busy_dout", bus.dout, 8'h5A);
      end
      check("busy_dir", bus.dir, 1);
    end
    check("busy_acks", acks, 1);
    check("busy_dout_hold", bus.dout, 8'h5A);
    // reset in second XFER cycle of a read
    bus.din = 8'h77;
    bus.req = 1'b1;
    bus.wr = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick;
      bus.req = 1'b0;
    end
    check("abort_en_pre", bus.en, 1);
    nreset = 1'b0;
    tick;
    nreset = 1'b1;
    check("abort_en", bus.en, 0);
    check("abort_ack", bus.ack, 0);
    check("abort_rdata", bus.rdata, 8'h00);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (bus.ack) acks++;
    end
    check("abort_noack", acks, 0);
    check("abort_rdata_post", bus.rdata, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
